// File: rtl/jt51_i2s_tx_if.sv
// Sample-side input bus and I2S/status output bundle for jt51_i2s_tx.
// The slave modport is the transmitter; the master modport is the sample source / DAC side.
interface jt51_i2s_tx_if;
    logic        sample;
    logic [15:0] left_in;
    logic [15:0] right_in;
    logic        i2s_bclk;
    logic        i2s_lrclk;
    logic        i2s_sdata;
    logic        frame_load;
    logic        overrun;
    logic        underrun;

    modport slave (
        input  sample, left_in, right_in,
        output i2s_bclk, i2s_lrclk, i2s_sdata, frame_load, overrun, underrun
    );

    modport master (
        output sample, left_in, right_in,
        input  i2s_bclk, i2s_lrclk, i2s_sdata, frame_load, overrun, underrun
    );
endinterface

// File: rtl/jt51_i2s_tx.sv
// I2S transmitter for the jt51 left/right sums: one-entry holding buffer feeding a 32-bit
// frame shifter, with bclk/lrclk generation and overrun/underrun pulses.
module jt51_i2s_tx #(
    parameter int unsigned BCLK_DIV = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    jt51_i2s_tx_if.slave  bus
);
    localparam int unsigned DivW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam logic [DivW-1:0] DivMax = DivW'(BCLK_DIV - 1);

    logic [DivW-1:0] div_cnt_q, div_cnt_d;
    logic            bclk_q, bclk_d;
    logic [4:0]      slot_q, slot_d;
    logic            lrclk_q, lrclk_d;
    logic            sdata_q, sdata_d;
    logic [31:0]     shifter_q, shifter_d;
    logic [15:0]     hold_l_q, hold_l_d;
    logic [15:0]     hold_r_q, hold_r_d;
    logic            hold_valid_q, hold_valid_d;
    logic            frame_load_q, frame_load_d;
    logic            overrun_q, overrun_d;
    logic            underrun_q, underrun_d;

    logic wrap, fall, load;

    assign wrap = (div_cnt_q == DivMax);
    assign fall = wrap & bclk_q;
    assign load = fall & (slot_q == 5'd31);

    always_comb begin
        div_cnt_d    = wrap ? '0 : div_cnt_q + 1'b1;
        bclk_d       = bclk_q ^ wrap;
        slot_d       = slot_q;
        lrclk_d      = lrclk_q;
        sdata_d      = sdata_q;
        shifter_d    = shifter_q;
        hold_l_d     = hold_l_q;
        hold_r_d     = hold_r_q;
        hold_valid_d = hold_valid_q;
        frame_load_d = 1'b0;
        overrun_d    = 1'b0;
        underrun_d   = 1'b0;

        if (fall) begin
            slot_d  = slot_q + 5'd1;
            // lrclk leads the data by one slot: high for slots 15..30
            lrclk_d = (slot_d >= 5'd15) && (slot_d <= 5'd30);
            if (load) begin
                // Hold regs keep the last sent pair when empty, so an underrun repeats it
                shifter_d    = {hold_l_q, hold_r_q};
                frame_load_d = 1'b1;
                underrun_d   = ~hold_valid_q;
                hold_valid_d = 1'b0;
            end else begin
                shifter_d = {shifter_q[30:0], 1'b0};
            end
            sdata_d = shifter_d[31];
        end

        if (bus.sample) begin
            hold_l_d     = bus.left_in;
            hold_r_d     = bus.right_in;
            hold_valid_d = 1'b1;
            overrun_d    = hold_valid_q & ~load;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q    <= '0;
            bclk_q       <= 1'b0;
            slot_q       <= 5'd31;
            lrclk_q      <= 1'b0;
            sdata_q      <= 1'b0;
            shifter_q    <= '0;
            hold_l_q     <= '0;
            hold_r_q     <= '0;
            hold_valid_q <= 1'b0;
            frame_load_q <= 1'b0;
            overrun_q    <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            div_cnt_q    <= div_cnt_d;
            bclk_q       <= bclk_d;
            slot_q       <= slot_d;
            lrclk_q      <= lrclk_d;
            sdata_q      <= sdata_d;
            shifter_q    <= shifter_d;
            hold_l_q     <= hold_l_d;
            hold_r_q     <= hold_r_d;
            hold_valid_q <= hold_valid_d;
            frame_load_q <= frame_load_d;
            overrun_q    <= overrun_d;
            underrun_q   <= underrun_d;
        end
    end

    assign bus.i2s_bclk   = bclk_q;
    assign bus.i2s_lrclk  = lrclk_q;
    assign bus.i2s_sdata  = sdata_q;
    assign bus.frame_load = frame_load_q;
    assign bus.overrun    = overrun_q;
    assign bus.underrun   = underrun_q;
endmodule

// File: doc/jt51_i2s_tx.md
Name: jt51_i2s_tx

Overview:
- Output stage directly downstream of the channel accumulator.
- Captures the exact 16-bit signed left/right sums once per sample and serialises them as a standard I2S stream (bclk, lrclk, sdata) for an external DAC.
- A single-entry holding buffer decouples the FM sample timing from the I2S frame timing, with overrun and underrun reporting.
- All outputs are registered, and the block runs on the synthesiser clock.

Parameters:
BCLK_DIV, 4, clk cycles per bclk half-period (must be ≥1); bclk period = 2*BCLK_DIV clk.

Ports:
clk  in  1  system clock; all logic on posedge
rst_n  in  1  asynchronous, active-low reset
sample  in  1  one-clk strobe: left_in/right_in hold a new sample (driven on the cycle after the accumulator's exact outputs update)
left_in  in  16  signed left sample
right_in  in  16  signed right sample
i2s_bclk  out  1  bit clock
i2s_lrclk  out  1  word select; 0 = left, 1 = right
i2s_sdata  out  1  serial data, MSB first; changes on bclk falling edge
frame_load  out  1  one-clk pulse when a new frame is loaded into the shifter
overrun  out  1  one-clk pulse: sample arrived while the holding buffer was still full
underrun  out  1  one-clk pulse: frame loaded with no fresh sample available

Behaviour:
- Reset values (async on rst_n low):
  - div_cnt=0, i2s_bclk=0, slot=31.
  - i2s_lrclk=0, i2s_sdata=0, shifter=0.
  - hold_L=hold_R=0, hold_valid=0.
  - All pulse outputs 0.
- Divider:
  - div_cnt counts 0..BCLK_DIV-1 and wraps.
  - On the wrap cycle (div_cnt==BCLK_DIV-1), i2s_bclk toggles.
  - A "fall" event is the wrap cycle on which i2s_bclk is currently 1.
- Slots:
  - A 5-bit slot counter advances on each fall event (31 wraps to 0).
  - A 32-bit shifter emits its MSB on i2s_sdata at each fall event.
- Frame load (fall event where slot goes 31→0):
  - shifter ← {L,R}, where L,R = hold_L,hold_R if hold_valid, else the last transmitted pair (repeat).
  - i2s_sdata ← bit 31 of the new shifter.
  - frame_load=1 for that cycle.
  - underrun=1 if hold_valid was 0.
  - hold_valid ← 0.
- Any other fall event: shifter shifts left by one, zero fill; i2s_sdata ← new bit 31.
- Slot mapping:
  - Slots 0..15 carry left MSB..LSB; slots 16..31 carry right MSB..LSB.
  - i2s_lrclk is updated at fall events: 1 for slots 15..30, 0 for slots 31 and 0..14. This gives the standard I2S one-bit delay.
- Holding buffer:
  - On sample: hold_L←left_in, hold_R←right_in, hold_valid←1.
  - If hold_valid was already 1 and no frame load occurs that cycle: overrun=1 and old data is discarded.
- Sample on the frame-load cycle:
  - The frame load takes the OLD hold contents (or repeats if none).
  - The new sample is written and hold_valid ends at 1.
  - No overrun is reported.
  - underrun is reported if the old hold_valid was 0.
- Timing from reset release:
  - First bclk rise at clk cycle BCLK_DIV.
  - First fall event / frame_load at cycle 2*BCLK_DIV.
  - Frames then repeat every 64*BCLK_DIV clk.
- Latency: a sample captured before a frame load appears with its left MSB on i2s_sdata in the same cycle frame_load pulses.
- Reset mid-frame: everything returns to reset values immediately; the stream restarts as above, and the buffered sample is lost.
- Arithmetic: no rescaling or saturation. Data is transmitted as received in two's complement.

Test Plan:
- Reset then idle, BCLK_DIV=2:
  - i2s_bclk has period 4 clk.
  - frame_load pulses at cycle 4, then every 128 clk.
  - underrun pulses with each load.
  - i2s_sdata stays 0.
- Sample (left=16'h8001, right=16'h7FFE) one cycle before the first load:
  - Slots 0..15 read 1000000000000001.
  - Slots 16..31 read 0111111111111110.
  - lrclk falls one slot before slot 0 of the next frame and rises at slot 15.
  - No underrun on that load.
- No new sample for the next frame: the same 0x8001/0x7FFE is retransmitted and underrun pulses once.
- Two samples (0x1234/0x5678 then 0xABCD/0x0F0F) between frame loads:
  - overrun pulses on the second.
  - The next frame carries 0xABCD/0x0F0F.
- Sample 0x00FF/0xFF00 asserted exactly on the frame_load cycle with an empty buffer:
  - underrun=1, overrun=0, and the frame repeats old data.
  - The following frame carries 0x00FF/0xFF00.
- rst_n asserted low mid-frame (slot 20): all outputs are 0 immediately. After release, the first frame_load occurs at 2*BCLK_DIV and the old held sample is not sent.
